wave_mem_reader: RTL and testbench

//   Read-back side of the EPM1270 waveform memory. On USB command 5 (data transfer),

---
 rtl/wave_mem_reader.sv | 142 ++++++++++++++
 tb/tb_wave_mem_reader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_mem_reader.sv
// wave_mem_reader: streams 16-bit words from waveform SRAM to the USB FIFO.
// Low byte first, paced by txe_n; SRAM pins are driven only while busy.
module wave_mem_reader #(
    parameter int AW          = 20,
    parameter int DEFAULT_LEN = 128,
    parameter int RD_WAIT     = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [3:0]    cnt,
    input  logic [15:0]   DX,
    output logic [AW-1:0] adrs,
    output logic          cea,
    output logic          ceb,
    output logic          bh,
    output logic          bl,
    output logic          ocx,
    output logic          ocy,
    input  logic          txe_n,
    output logic [7:0]    UX,
    output logic          uwr,
    output logic          busy,
    output logic          done
);

    localparam int LW = 16;
    localparam logic [LW-1:0] LEN_INIT  = LW'(DEFAULT_LEN);
    localparam logic [2:0]    WAIT_INIT = 3'(RD_WAIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_TXLO  = 3'd4;
    localparam logic [2:0] S_TXHI  = 3'd5;
    localparam logic [2:0] S_NEXT  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q;
    logic [AW-1:0] ptr_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] rem_q;
    logic [2:0]    wcnt_q;
    logic [15:0]   word_q;
    logic [7:0]    ux_q;
    logic          zero_q;

    logic          start;
    logic          abort;
    logic          sram_en;
    logic          tx;
    logic [7:0]    tx_byte;

    assign start   = (cnt == 4'd5) && (cnt_q != 4'd5);
    assign abort   = (cnt == 4'd4) && (state_q != S_IDLE);
    assign sram_en = (state_q == S_ADDR) || (state_q == S_WAIT)
                   || (state_q == S_LATCH);
    assign tx      = ((state_q == S_TXLO) || (state_q == S_TXHI)) && !txe_n;
    assign tx_byte = (state_q == S_TXHI) ? word_q[15:8] : word_q[7:0];

    assign adrs = ptr_q;
    assign cea  = !sram_en;
    assign bh   = !sram_en;
    assign bl   = !sram_en;
    assign ocx  = !sram_en;
    assign ceb  = 1'b1;
    assign ocy  = 1'b1;
    assign uwr  = tx;
    assign UX   = tx ? tx_byte : ux_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE) || zero_q;

    // Next-state decode; an abort returns to idle from any active state
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (start && len_q != '0) state_d = S_ADDR;
                S_ADDR:  state_d = S_WAIT;
                S_WAIT:  if (wcnt_q == 3'd0) state_d = S_LATCH;
                S_LATCH: state_d = S_TXLO;
                S_TXLO:  if (!txe_n) state_d = S_TXHI;
                S_TXHI:  if (!txe_n) state_d = S_NEXT;
                S_NEXT:  state_d = (rem_q == LW'(1)) ? S_DONE : S_ADDR;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath registers: pointer, length, word latch and byte hold
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ptr_q   <= '0;
            len_q   <= LEN_INIT;
            rem_q   <= '0;
            wcnt_q  <= 3'd0;
            word_q  <= 16'd0;
            ux_q    <= 8'd0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt;
            zero_q  <= 1'b0;
            if (tx) begin
                ux_q <= tx_byte;
            end
            if (abort) begin
                ptr_q <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (cnt == 4'd2 || cnt == 4'd4) begin
                            ptr_q <= '0;
                        end
                        if (cnt == 4'd8) begin
                            len_q <= LEN_INIT;
                        end
                        if (start) begin
                            rem_q  <= len_q;
                            zero_q <= (len_q == '0);
                        end
                    end
                    S_ADDR:  wcnt_q <= WAIT_INIT;
                    S_WAIT:  wcnt_q <= wcnt_q - 3'd1;
                    S_LATCH: word_q <= DX;
                    S_NEXT: begin
                        ptr_q <= ptr_q + AW'(1);
                        rem_q <= rem_q - LW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wave_mem_reader.sv
// tb_wave_mem_reader: randomized-pacing scoreboard bench for wave_mem_reader.
// A second small instance (AW=4) exercises pointer wrap.
module tb_wave_mem_reader;

    localparam int LEN  = 128;
    localparam int WLEN = 7;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cycnt = 0;

    logic [3:0]  m_cnt;
    logic [15:0] m_dx;
    logic [19:0] m_adrs;
    logic        m_cea, m_ceb, m_bh, m_bl, m_ocx, m_ocy, m_txe;
    logic [7:0]  m_ux;
    logic        m_uwr, m_busy, m_done;

    logic [3:0]  w_cnt;
    logic [15:0] w_dx;
    logic [3:0]  w_adrs;
    logic        w_cea, w_ceb, w_bh, w_bl, w_ocx, w_ocy, w_txe;
    logic [7:0]  w_ux;
    logic        w_uwr, w_busy, w_done;

    int         m_ptr = 0;
    int         w_ptr = 0;
    int         m_aq[$];
    int         w_aq[$];
    logic [7:0] m_bq[$];
    logic [7:0] w_bq[$];
    int         m_dcnt = 0;
    int         w_dcnt = 0;
    int         m_nb = 0;
    int         m_done_cyc = 0;
    int         m_first_cyc = 0;
    int         m_start_cyc = 0;
    bit         m_arm = 0;
    bit         m_pcea = 1;
    bit         w_pcea = 1;

    always #4 clk = ~clk;

    // SRAM models: word at address a holds a+300, driven only when enabled
    assign m_dx = (!m_cea && !m_ocx) ? 16'(m_adrs + 20'd300) : 16'hDEAD;
    assign w_dx = (!w_cea && !w_ocx) ? 16'({12'd0, w_adrs} + 16'd300)
                                     : 16'hDEAD;

    wave_mem_reader #(.AW(20), .DEFAULT_LEN(LEN), .RD_WAIT(2)) u_dut (
        .CLK(clk), .RST(rst), .cnt(m_cnt), .DX(m_dx), .adrs(m_adrs),
        .cea(m_cea), .ceb(m_ceb), .bh(m_bh), .bl(m_bl), .ocx(m_ocx),
        .ocy(m_ocy), .txe_n(m_txe), .UX(m_ux), .uwr(m_uwr),
        .busy(m_busy), .done(m_done)
    );

    wave_mem_reader #(.AW(4), .DEFAULT_LEN(WLEN), .RD_WAIT(2)) u_wrap (
        .CLK(clk), .RST(rst), .cnt(w_cnt), .DX(w_dx), .adrs(w_adrs),
        .cea(w_cea), .ceb(w_ceb), .bh(w_bh), .bl(w_bl), .ocx(w_ocx),
        .ocy(w_ocy), .txe_n(w_txe), .UX(w_ux), .uwr(w_uwr),
        .busy(w_busy), .done(w_done)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a transfer of n words reads addresses ptr..ptr+n-1 mod 2^aw
    task automatic m_issue();
        int a;
        logic [15:0] w;
        for (int k = 0; k < LEN; k++) begin
            a = (m_ptr + k) % (1 << 20);
            w = 16'(a + 300);
            m_aq.push_back(a);
            m_bq.push_back(w[7:0]);
            m_bq.push_back(w[15:8]);
        end
        m_ptr       = (m_ptr + LEN) % (1 << 20);
        m_start_cyc = cycnt;
        m_arm       = 1;
        m_cnt       = 4'd5;
    endtask

    task automatic w_issue();
        int a;
        logic [15:0] w;
        for (int k = 0; k < WLEN; k++) begin
            a = (w_ptr + k) % 16;
            w = 16'(a + 300);
            w_aq.push_back(a);
            w_bq.push_back(w[7:0]);
            w_bq.push_back(w[15:8]);
        end
        w_ptr = (w_ptr + WLEN) % 16;
        w_cnt = 4'd5;
    endtask

    task automatic m_wait_done(input string nm, input int budget,
                               input bit tog);
        int base;
        int c;
        base = m_dcnt;
        c    = 0;
        while (m_dcnt == base && c < budget) begin
            tick();
            c++;
            if (tog && (c % 3) == 0) m_txe = !m_txe;
        end
        m_txe = 1'b0;
        repeat (3) tick();
        chk({nm, "_done_once"}, m_dcnt - base, 1);
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_ctl"}, {m_cea, m_ceb, m_bh, m_bl, m_ocx, m_ocy}, 6'h3F);
        chk({nm, "_adrs"}, m_adrs, 0);
        chk({nm, "_ux_uwr"}, {m_ux, m_uwr}, 0);
        chk({nm, "_busy_done"}, {m_busy, m_done}, 0);
    endtask

    initial forever begin
        @(posedge clk);
        cycnt++;
    end

    // Monitor: pops expected bytes/addresses whenever the DUTs present them
    initial forever begin
        @(negedge clk);
        chk("ocy_ceb", {m_ocy, m_ceb, w_ocy, w_ceb}, 4'hF);
        chk("en_group", {m_bh, m_bl, m_ocx, w_bh, w_bl, w_ocx},
            {{3{m_cea}}, {3{w_cea}}});
        if (m_uwr) begin
            chk("uwr_txe_busy", {m_txe, m_busy}, 2'b01);
            if (m_bq.size() == 0) chk("extra_byte", m_ux, 256);
            else chk("byte", m_ux, m_bq.pop_front());
            m_nb++;
            if (m_arm) begin
                m_first_cyc = cycnt;
                m_arm       = 0;
            end
        end
        if (!m_cea && m_pcea) begin
            if (m_aq.size() == 0) chk("extra_adrs", m_adrs, -1);
            else chk("adrs", m_adrs, m_aq.pop_front());
        end
        m_pcea = m_cea;
        if (m_done) begin
            m_dcnt++;
            m_done_cyc = cycnt;
        end
        if (w_uwr) begin
            chk("w_uwr_txe_busy", {w_txe, w_busy}, 2'b01);
            if (w_bq.size() == 0) chk("w_extra_byte", w_ux, 256);
            else chk("w_byte", w_ux, w_bq.pop_front());
        end
        if (!w_cea && w_pcea) begin
            if (w_aq.size() == 0) chk("w_extra_adrs", w_adrs, -1);
            else chk("w_adrs", w_adrs, w_aq.pop_front());
        end
        w_pcea = w_cea;
        if (w_done) w_dcnt++;
    end

    initial begin
        int nb0;
        int d0;
        int c;
        int base;
        rst   = 1'b1;
        m_cnt = 4'd0;
        w_cnt = 4'd0;
        m_txe = 1'b0;
        w_txe = 1'b0;
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // Wrap: four len-7 transfers on AW=4 cross 15->0 and continue at 5
        for (int t = 0; t < 4; t++) begin
            w_cnt = 4'd0;
            tick();
            base = w_dcnt;
            w_issue();
            c = 0;
            while (w_dcnt == base && c < 300) begin
                tick();
                c++;
            end
            chk("w_done", w_dcnt - base, 1);
        end
        w_cnt = 4'd0;
        repeat (3) tick();
        chk("w_queues_empty", w_aq.size() + w_bq.size(), 0);

        // Test 1: len set, full-speed transfer with latency checks
        m_cnt = 4'd8;
        tick();
        m_cnt = 4'd0;
        tick();
        nb0 = m_nb;
        m_issue();
        m_wait_done("t1", 2000, 0);
        chk("t1_bytes", m_nb - nb0, 2 * LEN);
        chk("t1_first_uwr", m_first_cyc - m_start_cyc, 5);
        chk("t1_done_cyc", m_done_cyc - m_start_cyc, 7 * LEN + 1);
        chk("t1_q_empty", m_bq.size() + m_aq.size(), 0);

        // Test 2: txe_n toggling, continues from ptr 128
        m_cnt = 4'd0;
        tick();
        nb0   = m_nb;
        m_txe = 1'b1;
        m_issue();
        m_wait_done("t2", 8000, 1);
        chk("t2_bytes", m_nb - nb0, 2 * LEN);
        chk("t2_q_empty", m_bq.size() + m_aq.size(), 0);

        // Test 4: abort after the 10th byte
        m_cnt = 4'd0;
        tick();
        nb0 = m_nb;
        m_issue();
        c = 0;
        while (m_nb - nb0 < 10 && c < 500) begin
            @(posedge clk);
            c++;
        end
        chk("t4_reach10", m_nb - nb0, 10);
        #1;
        m_cnt = 4'd4;
        d0    = m_dcnt;
        tick();
        chk("t4_abort", {m_busy, m_uwr, m_cea, m_ocx}, 4'b0011);
        m_cnt = 4'd0;
        repeat (20) tick();
        chk("t4_no_done", m_dcnt - d0, 0);
        chk("t4_bytes", m_nb - nb0, 10);
        m_ptr = 0;
        m_aq.delete();
        m_bq.delete();

        // Test 5: reset during WAIT; first adrs also confirms ptr=0 post-abort
        m_issue();
        tick();
        tick();
        rst   = 1'b1;
        m_cnt = 4'd0;
        tick();
        check_reset("t5_rst");
        rst   = 1'b0;
        m_ptr = 0;
        m_aq.delete();
        m_bq.delete();
        tick();
        nb0 = m_nb;
        m_issue();
        m_wait_done("t5", 2000, 0);
        chk("t5_bytes", m_nb - nb0, 2 * LEN);

        // Test 6: cnt held at 5 for 2000 cycles triggers exactly one transfer
        m_cnt = 4'd0;
        tick();
        nb0 = m_nb;
        d0  = m_dcnt;
        m_issue();
        repeat (2000) tick();
        chk("t6_one_done", m_dcnt - d0, 1);
        chk("t6_bytes", m_nb - nb0, 2 * LEN);
        chk("t6_q_empty", m_bq.size() + m_aq.size(), 0);
        m_cnt = 4'd0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
